hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Issue controller between the decoder and the register stage / register file.
//   Keeps a pending-write counter per architectural register.
//   Holds an instruction at issue while any source or destination register has
//   an outstanding write.
//   Releases a register when its writeback retires; provides a drain handshake
//   for pipeline flush.
// PARAMETERS
//   NUM_REGS  16  number of architectural registers (r0 is a normal register)
//   REG_AW    4   register index width, $clog2(NUM_REGS)
//   CNT_W     2   per-register pending counter width; max in-flight per reg = 2**CNT_W-1
//   TOT_W     6   width of total in-flight counter
// PORTS
//   clk          in   1         clock, all state on posedge
//   rst          in   1         asynchronous, active-high reset
//   iss_valid    in   1         decoder presents an instruction this cycle
//   iss_rs1_en   in   1         instruction reads rs1
//   iss_rs1      in   REG_AW    source register 1 index
//   iss_rs2_en   in   1         instruction reads rs2
//   iss_rs2      in   REG_AW    source register 2 index
//   iss_rd_en    in   1         instruction writes rd
//   iss_rd       in   REG_AW    destination register index
//   iss_ready    out  1         issue accepted when iss_valid & iss_ready
//   wb_valid     in   1         one register write retires this cycle
//   wb_rd        in   REG_AW    register being written back
//   drain_req    in   1         level; request to stop issue and drain in-flight writes
//   drain_done   out  1         one-cycle pulse: drain complete, scoreboard empty
//   busy_mask    out  NUM_REGS  bit i = pend_cnt[i] != 0 (registered)
//   inflight     out  TOT_W     sum of all pending counters (registered)
//   err_underflow out 1         sticky: wb_valid to a register with pend_cnt==0
// BEHAVIOUR
//   Reset (async, immediate): all pend_cnt=0, state=RUN, iss_ready=0 while rst=1,
//     drain_done=0, busy_mask=0, inflight=0, err_underflow=0.
//   Hazard (combinational, from registered counters only; no same-cycle bypass):
//     hz = (rs1_en & cnt[rs1]!=0) | (rs2_en & cnt[rs2]!=0) | (rd_en & cnt[rd]==MAX)
//     WAW allowed until saturation.
//   iss_ready = (state==RUN) & ~drain_req & ~hz & ~rst. Valid whether or not
//     iss_valid is high; decoder must hold the instruction while not ready.
//   Accept (iss_valid & iss_ready & iss_rd_en): cnt[rd] += 1 next edge, inflight += 1.
//   Writeback (wb_valid): if cnt[wb_rd]!=0, cnt[wb_rd] -= 1 and inflight -= 1;
//     else counter stays 0, err_underflow set to 1 until reset.
//   Same register accepted and retired in one cycle: cnt and inflight unchanged.
//   A writeback releasing a source is seen by issue the following cycle:
//     minimum RAW issue-to-issue gap = wb cycle + 1.
//   Counters never wrap: increment blocked at MAX via hz; decrement blocked at 0.
//   FSM:
//     RUN   -> DRAIN when drain_req=1.
//     DRAIN -> DONE when inflight==0 and no wb this cycle, else stay.
//              Entry with inflight==0 reaches DONE next cycle.
//     DONE  -> drain_done=1 for this cycle. Goes to DRAIN if drain_req still 1,
//              RUN if drain_req=0.
//     DRAIN with drain_req deasserted stays in DRAIN until empty, then DONE.
//   iss_ready=0 in DRAIN and DONE. Writebacks are processed in all states.
//   busy_mask and inflight reflect post-edge counter values.
// TESTING
//   1 Reset mid-operation: cnt[3]=2, inflight=2, assert rst between edges ->
//     busy_mask=0, inflight=0, iss_ready=0 immediately.
//     After release, RAW on r3 issues in 1 cycle.
//   2 RAW stall: issue rd=r0; next instr rs1=r0 -> iss_ready=0.
//     wb_rd=0 at cycle N -> iss_ready=1 at cycle N+1, busy_mask[0] 1->0.
//   3 WAW saturation (CNT_W=2): 3 accepts rd=r5 -> cnt[5]=3, 4th rd=r5 held ready=0.
//     One wb r5 -> accepted next cycle, inflight=3.
//   4 Simultaneous accept rd=r2 and wb r2 with cnt[2]=1 -> cnt[2]=1, inflight unchanged.
//     wb r7 with cnt[7]=0 -> err_underflow=1, inflight unchanged.
//   5 Drain: inflight=2, drain_req=1 -> ready=0 same cycle; 2 wbs ->
//     drain_done pulses exactly 1 cycle after last wb. drain_req=0 -> RUN, ready=1.
//   6 Drain with empty scoreboard: drain_req pulse 1 cycle ->
//     drain_done pulse 2 cycles later, then RUN.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Issue / writeback / drain bundle between decoder, scoreboard and register stage.
// The decoder side drives the master modport; the scoreboard uses the slave modport.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4,
  parameter int TOT_W    = 6
);
  logic                iss_valid;
  logic                iss_rs1_en;
  logic [REG_AW-1:0]   iss_rs1;
  logic                iss_rs2_en;
  logic [REG_AW-1:0]   iss_rs2;
  logic                iss_rd_en;
  logic [REG_AW-1:0]   iss_rd;
  logic                iss_ready;
  logic                wb_valid;
  logic [REG_AW-1:0]   wb_rd;
  logic                drain_req;
  logic                drain_done;
  logic [NUM_REGS-1:0] busy_mask;
  logic [TOT_W-1:0]    inflight;
  logic                err_underflow;

  modport master (
    output iss_valid, iss_rs1_en, iss_rs1, iss_rs2_en, iss_rs2, iss_rd_en, iss_rd,
    output wb_valid, wb_rd, drain_req,
    input  iss_ready, drain_done, busy_mask, inflight, err_underflow
  );

  modport slave (
    input  iss_valid, iss_rs1_en, iss_rs1, iss_rs2_en, iss_rs2, iss_rd_en, iss_rd,
    input  wb_valid, wb_rd, drain_req,
    output iss_ready, drain_done, busy_mask, inflight, err_underflow
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard: stalls issue on RAW/saturated WAW hazards,
// releases registers on writeback and offers a drain handshake for flushes.
module hazard_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4,
  parameter int CNT_W    = 2,
  parameter int TOT_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [CNT_W-1:0]               r_cnt [NUM_REGS];
  logic [TOT_W-1:0]               r_inflight;
  logic                           r_err;
  logic [NUM_REGS-1:0]            w_nz;
  logic [NUM_REGS-1:0]            w_inc;
  logic [NUM_REGS-1:0]            w_dec;
  logic                           w_hz;
  logic                           w_run;
  logic                           w_ready;
  logic                           w_accept;
  logic                           w_drain_done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign w_nz[gi]  = (r_cnt[gi] != '0);
      assign w_inc[gi] = w_accept & bus.iss_rd_en & (bus.iss_rd == REG_AW'(gi));
      // Decrement is suppressed at zero so a stray writeback cannot wrap the counter.
      assign w_dec[gi] = bus.wb_valid & (bus.wb_rd == REG_AW'(gi)) & w_nz[gi];
    end
  endgenerate

  assign w_hz = (bus.iss_rs1_en & w_nz[bus.iss_rs1])
              | (bus.iss_rs2_en & w_nz[bus.iss_rs2])
              | (bus.iss_rd_en  & (r_cnt[bus.iss_rd] == CNT_MAX));

  assign w_ready  = w_run & ~bus.drain_req & ~w_hz & ~rst;
  assign w_accept = bus.iss_valid & w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc[i] & ~w_dec[i])      r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] & ~w_inc[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
      if ((|w_inc) & ~(|w_dec))      r_inflight <= r_inflight + TOT_W'(1);
      else if ((|w_dec) & ~(|w_inc)) r_inflight <= r_inflight - TOT_W'(1);
      if (bus.wb_valid & ~w_nz[bus.wb_rd]) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:   if (bus.drain_req) w_state_next = S_DRAIN;
      S_DRAIN: if ((r_inflight == '0) && !bus.wb_valid) w_state_next = S_DONE;
      S_DONE:  w_state_next = bus.drain_req ? S_DRAIN : S_RUN;
      default: w_state_next = S_RUN;
    endcase
  end

  always_comb begin
    w_run        = (r_state == S_RUN);
    w_drain_done = (r_state == S_DONE);
  end

  assign bus.iss_ready     = w_ready;
  assign bus.drain_done    = w_drain_done;
  assign bus.busy_mask     = w_nz;
  assign bus.inflight      = r_inflight;
  assign bus.err_underflow = r_err;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios followed by a randomized run checked against a per-register
// pending-count model of the scoreboard.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_cnt [16];
  bit   m_err;

  hazard_scoreboard_if #(.NUM_REGS(16), .REG_AW(4), .TOT_W(6)) bus ();

  hazard_scoreboard #(.NUM_REGS(16), .REG_AW(4), .CNT_W(2), .TOT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_iss(input logic v, input logic e1, input logic [3:0] a1,
                         input logic e2, input logic [3:0] a2,
                         input logic ed, input logic [3:0] d);
    bus.iss_valid  = v;
    bus.iss_rs1_en = e1; bus.iss_rs1 = a1;
    bus.iss_rs2_en = e2; bus.iss_rs2 = a2;
    bus.iss_rd_en  = ed; bus.iss_rd  = d;
  endtask

  task automatic set_wb(input logic v, input logic [3:0] r);
    bus.wb_valid = v;
    bus.wb_rd    = r;
  endtask

  initial begin
    logic [15:0] exp_mask;
    int          exp_sum;
    logic        exp_rdy, acc;
    logic        v, e1, e2, ed, wv;
    logic [3:0]  a1, a2, d, wr;

    set_iss(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    bus.drain_req = 1'b0;
    #2;
    chk("reset_ready", 32'(bus.iss_ready), 0);
    chk("reset_busy", 32'(bus.busy_mask), 0);
    chk("reset_inflight", 32'(bus.inflight), 0);
    chk("reset_done", 32'(bus.drain_done), 0);
    chk("reset_err", 32'(bus.err_underflow), 0);
    tick(); tick();
    rst = 1'b0;

    // 1: async reset mid-operation
    set_iss(1, 0, 0, 0, 0, 1, 3);
    #1 chk("t1_ready_a", 32'(bus.iss_ready), 1);
    tick();
    chk("t1_ready_b", 32'(bus.iss_ready), 1);
    tick();
    chk("t1_inflight", 32'(bus.inflight), 2);
    chk("t1_busy", 32'(bus.busy_mask), 32'h0008);
    set_iss(1, 1, 3, 0, 0, 0, 0);
    #1 chk("t1_raw_stall", 32'(bus.iss_ready), 0);
    #1 rst = 1'b1;
    #1;
    chk("t1_rst_busy", 32'(bus.busy_mask), 0);
    chk("t1_rst_inflight", 32'(bus.inflight), 0);
    chk("t1_rst_ready", 32'(bus.iss_ready), 0);
    tick();
    rst = 1'b0;
    #1 chk("t1_raw_after_rst", 32'(bus.iss_ready), 1);
    tick();
    $display("t1 reset mid-operation done");

    // 2: RAW stall released by writeback
    set_iss(1, 0, 0, 0, 0, 1, 0);
    #1 chk("t2_issue_rd0", 32'(bus.iss_ready), 1);
    tick();
    set_iss(1, 1, 0, 0, 0, 0, 0);
    #1 chk("t2_stall", 32'(bus.iss_ready), 0);
    chk("t2_busy_set", 32'(bus.busy_mask), 32'h0001);
    tick();
    set_wb(1, 0);
    #1 chk("t2_no_bypass", 32'(bus.iss_ready), 0);
    tick();
    set_wb(0, 0);
    #1 chk("t2_release", 32'(bus.iss_ready), 1);
    chk("t2_busy_clr", 32'(bus.busy_mask), 0);
    tick();
    set_iss(0, 0, 0, 0, 0, 0, 0);
    $display("t2 RAW stall done");

    // 3: WAW saturation
    set_iss(1, 0, 0, 0, 0, 1, 5);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_waw_ok", 32'(bus.iss_ready), 1);
      tick();
    end
    #1 chk("t3_sat_stall", 32'(bus.iss_ready), 0);
    chk("t3_inflight3", 32'(bus.inflight), 3);
    chk("t3_busy", 32'(bus.busy_mask), 32'h0020);
    set_wb(1, 5);
    #1 chk("t3_wb_cycle", 32'(bus.iss_ready), 0);
    tick();
    set_wb(0, 0);
    #1 chk("t3_unsat", 32'(bus.iss_ready), 1);
    tick();
    set_iss(0, 0, 0, 0, 0, 0, 0);
    chk("t3_inflight_after", 32'(bus.inflight), 3);
    set_wb(1, 5);
    tick(); tick(); tick();
    set_wb(0, 0);
    chk("t3_drained", 32'(bus.inflight), 0);
    $display("t3 WAW saturation done");

    // 4: accept+retire same register, underflow
    set_iss(1, 0, 0, 0, 0, 1, 2);
    tick();
    set_wb(1, 2);
    #1 chk("t4_ready", 32'(bus.iss_ready), 1);
    tick();
    set_iss(0, 0, 0, 0, 0, 0, 0);
    chk("t4_inflight", 32'(bus.inflight), 1);
    chk("t4_busy", 32'(bus.busy_mask), 32'h0004);
    set_wb(1, 7);
    tick();
    set_wb(0, 0);
    chk("t4_err", 32'(bus.err_underflow), 1);
    chk("t4_inflight_uf", 32'(bus.inflight), 1);
    set_wb(1, 2);
    tick();
    set_wb(0, 0);
    chk("t4_empty", 32'(bus.inflight), 0);
    $display("t4 simultaneous/underflow done");

    // 5: drain with two outstanding writes
    set_iss(1, 0, 0, 0, 0, 1, 8);
    tick();
    set_iss(1, 0, 0, 0, 0, 1, 9);
    tick();
    chk("t5_inflight", 32'(bus.inflight), 2);
    set_iss(1, 0, 0, 0, 0, 1, 10);
    bus.drain_req = 1'b1;
    #1 chk("t5_ready_drop", 32'(bus.iss_ready), 0);
    tick();
    set_iss(0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 8);
    #1 chk("t5_done_wb1", 32'(bus.drain_done), 0);
    tick();
    set_wb(1, 9);
    #1 chk("t5_done_wb2", 32'(bus.drain_done), 0);
    tick();
    set_wb(0, 0);
    chk("t5_empty", 32'(bus.inflight), 0);
    chk("t5_done_early", 32'(bus.drain_done), 0);
    tick();
    chk("t5_done_pulse", 32'(bus.drain_done), 1);
    bus.drain_req = 1'b0;
    tick();
    chk("t5_done_end", 32'(bus.drain_done), 0);
    set_iss(1, 0, 0, 0, 0, 0, 0);
    #1 chk("t5_run_ready", 32'(bus.iss_ready), 1);
    tick();
    set_iss(0, 0, 0, 0, 0, 0, 0);
    $display("t5 drain done");

    // 6: drain pulse on empty scoreboard
    bus.drain_req = 1'b1;
    tick();
    bus.drain_req = 1'b0;
    set_iss(1, 0, 0, 0, 0, 0, 0);
    #1 chk("t6_c1_done", 32'(bus.drain_done), 0);
    chk("t6_c1_ready", 32'(bus.iss_ready), 0);
    tick();
    chk("t6_c2_done", 32'(bus.drain_done), 1);
    chk("t6_c2_ready", 32'(bus.iss_ready), 0);
    tick();
    chk("t6_c3_done", 32'(bus.drain_done), 0);
    chk("t6_c3_ready", 32'(bus.iss_ready), 1);
    set_iss(0, 0, 0, 0, 0, 0, 0);
    $display("t6 empty drain done");

    // Randomized run against a pending-count model
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    for (int n = 0; n < 250; n++) begin
      v  = 1'($urandom_range(0, 1));
      e1 = 1'($urandom_range(0, 1)); a1 = 4'($urandom_range(0, 3));
      e2 = 1'($urandom_range(0, 1)); a2 = 4'($urandom_range(0, 3));
      ed = 1'($urandom_range(0, 3) != 0); d = 4'($urandom_range(0, 3));
      wv = 1'($urandom_range(0, 2) == 0); wr = 4'($urandom_range(0, 3));
      set_iss(v, e1, a1, e2, a2, ed, d);
      set_wb(wv, wr);
      exp_rdy = !((e1 && m_cnt[a1] > 0) || (e2 && m_cnt[a2] > 0) || (ed && m_cnt[d] >= 3));
      #1 chk("rnd_ready", 32'(bus.iss_ready), 32'(exp_rdy));
      acc = v && exp_rdy && ed;
      if (wv) begin
        if (m_cnt[wr] > 0) m_cnt[wr] = m_cnt[wr] - 1;
        else m_err = 1'b1;
      end
      if (acc) m_cnt[d] = m_cnt[d] + 1;
      tick();
      exp_mask = '0;
      exp_sum  = 0;
      for (int i = 0; i < 16; i++) begin
        exp_mask[i] = (m_cnt[i] > 0);
        exp_sum     = exp_sum + m_cnt[i];
      end
      chk("rnd_busy", 32'(bus.busy_mask), 32'(exp_mask));
      chk("rnd_inflight", 32'(bus.inflight), 32'(exp_sum));
      chk("rnd_err", 32'(bus.err_underflow), 32'(m_err));
      $display("rnd %0d: v=%0b rs1=%0b/%0d rs2=%0b/%0d rd=%0b/%0d wb=%0b/%0d rdy=%0b inflight=%0d",
               n, v, e1, a1, e2, a2, ed, d, wv, wr, exp_rdy, exp_sum);
    end
    set_iss(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
